// File: rtl/gcd_seq.sv
// rtl/gcd_seq.sv - Euclid GCD sequencer that drives an external mod unit; optional WAIT timeout under GCD_TIMEOUT_EN
module gcd_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_gcd,
  output logic [5:0]  out_iter,
  output logic        out_err,
  output logic        mod_run,
  output logic [31:0] mod_a,
  output logic [31:0] mod_b,
  input  logic [31:0] mod_result,
  input  logic        mod_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ISSUE  = 3'd2,
    SETTLE = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_n;

  // Working operands; they double as the mod unit request so they stay
  // untouched from ISSUE through WAIT.
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [5:0]  iter_q;
  logic [31:0] gcd_q;
  logic        err_q;
  // Set only for the first CHECK after a handshake: later operands are mod
  // results and can never grow past the original values.
  logic        first_q;

  logic        range_err;
  logic        timeout_hit;

  assign range_err = first_q && (a_q[31] || b_q[31]);

`ifdef GCD_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  assign timeout_hit = !mod_ready && (wait_cnt == CNT_LAST);

  // Cycles spent in WAIT for the current mod operation, cleared in ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !mod_ready && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES has no effect in this build; a zero value would only be
  // meaningful with the timeout compiled in, so nothing is generated here.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode and handshake/request outputs
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    mod_run   = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (range_err || (b_q == 32'd0)) begin
          state_n = DONE;
        end else begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        mod_run = 1'b1;
        state_n = SETTLE;
      end
      SETTLE: begin
        // mod_ready may still be high from the previous operation here
        state_n = WAIT;
      end
      WAIT: begin
        if (mod_ready) begin
          state_n = CHECK;
        end else if (timeout_hit) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath: operand latch, Euclid step, result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      iter_q  <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            iter_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
          end
        end
        CHECK: begin
          first_q <= 1'b0;
          if (range_err) begin
            gcd_q <= '0;
            err_q <= 1'b1;
          end else if (b_q == 32'd0) begin
            gcd_q <= a_q;
          end
        end
        WAIT: begin
          if (mod_ready) begin
            a_q    <= b_q;
            b_q    <= mod_result;
            iter_q <= iter_q + 6'd1;
          end else if (timeout_hit) begin
            gcd_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mod_a    = a_q;
  assign mod_b    = b_q;
  assign out_gcd  = gcd_q;
  assign out_iter = iter_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_gcd_seq.sv
// tb/tb_gcd_seq.sv - randomized self-checking bench for gcd_seq with a behavioural GCD model and mod-unit stub
module tb_gcd_seq;

  localparam int TO      = 16;
  localparam int MAX_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_gcd;
  logic [5:0]  out_iter;
  logic        out_err;
  logic        mod_run;
  logic [31:0] mod_a;
  logic [31:0] mod_b;
  logic [31:0] mod_result;
  logic        mod_ready;

  int tests  = 0;
  int failed = 0;

  int   mod_runs  = 0;
  bit   run_long  = 0;
  logic prev_run  = 1'b0;
  bit   stub_dead = 0;

  logic        stub_pend;
  logic        stub_busy;
  int          stub_cnt;
  logic [31:0] stub_val;

  always #5 clk = ~clk;

  gcd_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_iter   (out_iter),
    .out_err    (out_err),
    .mod_run    (mod_run),
    .mod_a      (mod_a),
    .mod_b      (mod_b),
    .mod_result (mod_result),
    .mod_ready  (mod_ready)
  );

  // Mod unit stub: ready stays stale for one cycle after mod_run, then drops
  // with junk on the result bus, then rises after a random latency.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_ready  <= 1'b0;
      mod_result <= '0;
      stub_pend  <= 1'b0;
      stub_busy  <= 1'b0;
      stub_cnt   <= 0;
      stub_val   <= '0;
    end else if (mod_run) begin
      stub_pend <= 1'b1;
      stub_val  <= (mod_b != 0) ? (mod_a % mod_b) : 32'hDEAD_BEEF;
    end else if (stub_pend) begin
      stub_pend  <= 1'b0;
      stub_busy  <= 1'b1;
      mod_ready  <= 1'b0;
      mod_result <= $urandom;
      stub_cnt   <= $urandom_range(0, MAX_LAT);
    end else if (stub_busy && !stub_dead) begin
      if (stub_cnt == 0) begin
        mod_ready  <= 1'b1;
        mod_result <= stub_val;
        stub_busy  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Count mod_run pulses and flag any pulse wider than one cycle
  always @(posedge clk) begin
    if (mod_run) mod_runs <= mod_runs + 1;
    if (mod_run && prev_run) run_long <= 1'b1;
    prev_run <= mod_run;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain Euclid on integers, counting mod operations
  function automatic void ref_gcd(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] g, output int it, output bit er);
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] t;
    x  = a;
    y  = b;
    it = 0;
    er = 0;
    g  = 0;
    if (x[31] || y[31]) begin
      er = 1;
      return;
    end
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
      it++;
    end
    g = x;
  endfunction

  // One full transaction starting and ending on a falling edge
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] g;
    int          it;
    bit          er;
    int          cyc;
    int          runs0;
    int          bound;
    logic [31:0] g_seen;
    ref_gcd(a, b, g, it, er);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    runs0    = mod_runs;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    bound    = 2 + it * (3 + MAX_LAT + 2) + 1;
    cyc      = 1;
    while (!out_valid && cyc <= bound + 5) begin
      @(negedge clk);
      cyc++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    check("latency_bound", {31'd0, (cyc <= bound)}, 32'd1);
    check("gcd", out_gcd, g);
    check("iter", {26'd0, out_iter}, it);
    check("err", {31'd0, out_err}, {31'd0, er});
    check("mod_run_count", mod_runs - runs0, it);
    g_seen = out_gcd;
    for (int h = 0; h < hold; h++) begin
      out_ready = $urandom_range(0, 1) == 0 ? 1'b0 : 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_gcd", out_gcd, g_seen);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_next", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wait_mod_run(output bit seen);
    int cyc;
    cyc  = 0;
    seen = 0;
    while (!mod_run && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    seen = mod_run;
  endtask

  initial begin
    bit          seen;
    int          kind;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] m;
    int          cyc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mod_run", {31'd0, mod_run}, 32'd0);
    check("rst_out_gcd", out_gcd, 32'd0);
    check("rst_out_iter", {26'd0, out_iter}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_mod_a", mod_a, 32'd0);
    check("rst_mod_b", mod_b, 32'd0);

    do_op(32'd48, 32'd18, 0);
    do_op(32'd0, 32'd0, 0);
    do_op(32'd7, 32'd0, 1);
    do_op(32'd0, 32'd5, 0);
    do_op(32'h8000_0000, 32'd3, 0);
    do_op(32'd3, 32'h8000_0000, 0);
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFE, 0);
    do_op(32'd1071, 32'd462, 10);

    // Reset in the middle of the second mod operation
    in_valid = 1'b1;
    in_a     = 32'd1071;
    in_b     = 32'd462;
    @(negedge clk);
    in_valid = 1'b0;
    wait_mod_run(seen);
    @(negedge clk);
    wait_mod_run(seen);
    check("saw_mod_run", {31'd0, seen}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_mod_run", {31'd0, mod_run}, 32'd0);
    check("async_out_gcd", out_gcd, 32'd0);
    check("async_out_iter", {26'd0, out_iter}, 32'd0);
    check("async_out_err", {31'd0, out_err}, 32'd0);
    check("async_mod_a", mod_a, 32'd0);
    check("async_mod_b", mod_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    do_op(32'd12, 32'd8, 0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom & 32'h7FFF_FFFF; rb = $urandom & 32'h7FFF_FFFF; end
        2: begin ra = $urandom_range(0, 20); rb = $urandom_range(0, 20); end
        3: begin
          m  = $urandom_range(1, 1000);
          ra = m * $urandom_range(1, 1000000);
          rb = m * $urandom_range(1, 1000000);
        end
        default: begin
          ra = $urandom_range(0, 1) == 1 ? 32'd0 : ($urandom & 32'h7FFF_FFFF);
          rb = (ra == 0) ? ($urandom & 32'h7FFF_FFFF) : 32'd0;
        end
      endcase
      do_op(ra, rb, $urandom_range(0, 3));
    end

`ifdef GCD_TIMEOUT_EN
    stub_dead = 1;
    in_valid  = 1'b1;
    in_a      = 32'd9;
    in_b      = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    wait_mod_run(seen);
    check("to_saw_mod_run", {31'd0, seen}, 32'd1);
    cyc = 0;
    while (!out_valid && cyc < TO + 20) begin
      @(negedge clk);
      cyc++;
    end
    check("to_cycles", cyc, TO + 2);
    check("to_err", {31'd0, out_err}, 32'd1);
    check("to_gcd", out_gcd, 32'd0);
    check("to_iter", {26'd0, out_iter}, 32'd0);
    check("to_mod_run", {31'd0, mod_run}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    stub_dead = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(32'd9, 32'd4, 0);
`else
    cyc = 0;
`endif

    check("mod_run_width", {31'd0, run_long}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
